// File: rtl/bbara_pkg.sv
// rtl/bbara_pkg.sv - shared widths, defaults and debounce state type for the bbara control path
package bbara_pkg;

    localparam int BBARA_IN_W        = 4;
    localparam int BBARA_OUT_W       = 2;
    localparam int DB_CYCLES_DEFAULT = 4;

    typedef enum logic {
        STABLE   = 1'b0,
        COUNTING = 1'b1
    } db_state_e;

endpackage

// File: rtl/bbara_input_conditioner_if.sv
// rtl/bbara_input_conditioner_if.sv - raw input / conditioned output bundle of the bbara input conditioner
// master: source of raw_in, consumer of bbara_in/rise/fall/changed
// slave : the conditioner itself
interface bbara_input_conditioner_if;
    import bbara_pkg::*;

    logic [BBARA_IN_W-1:0] raw_in;
    logic [BBARA_IN_W-1:0] bbara_in;
    logic [BBARA_IN_W-1:0] rise;
    logic [BBARA_IN_W-1:0] fall;
    logic                  changed;

    modport master (output raw_in, input bbara_in, rise, fall, changed);
    modport slave  (input raw_in, output bbara_in, rise, fall, changed);

endinterface

// File: rtl/bbara_debounce_bit.sv
// rtl/bbara_debounce_bit.sv - one-bit synchronizer, debounce counter and edge pulse generator
// clock, reset  : clock and async active-low reset
// raw_i         : asynchronous raw input bit
// level_o       : debounced level (registered)
// rise_o/fall_o : one-cycle pulses concurrent with a level_o update (registered)
// update_d_o    : next-edge update strobe, lets the top register a single change pulse
module bbara_debounce_bit
    import bbara_pkg::*;
#(
    parameter int DB_CYCLES = DB_CYCLES_DEFAULT,
    parameter int CNT_W     = 8
) (
    input  logic clock,
    input  logic reset,
    input  logic raw_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o,
    output logic update_d_o
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

    logic             s1_q, s2_q;
    logic             level_q, level_d;
    logic             rise_q, fall_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    db_state_e        state_q, state_d;
    logic             update;

    always_comb begin
        level_d = level_q;
        cnt_d   = cnt_q;
        state_d = state_q;
        update  = 1'b0;
        case (state_q)
            STABLE: begin
                if (s2_q != level_q) begin
                    // With a one-cycle window the first disagreeing sample is already enough.
                    if (DB_CYCLES == 1) begin
                        update = 1'b1;
                    end else begin
                        cnt_d   = CNT_W'(1);
                        state_d = COUNTING;
                    end
                end
            end
            COUNTING: begin
                if (s2_q == level_q) begin
                    cnt_d   = '0;
                    state_d = STABLE;
                end else if (cnt_q == CNT_LAST) begin
                    update  = 1'b1;
                    cnt_d   = '0;
                    state_d = STABLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = STABLE;
            end
        endcase
        if (update) begin
            level_d = s2_q;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            s1_q    <= 1'b0;
            s2_q    <= 1'b0;
            level_q <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
            cnt_q   <= '0;
            state_q <= STABLE;
        end else begin
            s1_q    <= raw_i;
            s2_q    <= s1_q;
            level_q <= level_d;
            rise_q  <= update & s2_q;
            fall_q  <= update & ~s2_q;
            cnt_q   <= cnt_d;
            state_q <= state_d;
        end
    end

    assign level_o    = level_q;
    assign rise_o     = rise_q;
    assign fall_o     = fall_q;
    assign update_d_o = update;

endmodule

// File: rtl/bbara_input_conditioner.sv
// rtl/bbara_input_conditioner.sv - synchronizes and debounces the four bbara raw inputs
// clock, reset : clock and async active-low reset
// cond (slave) : raw_in in; bbara_in, rise, fall, changed out (all registered)
module bbara_input_conditioner
    import bbara_pkg::*;
#(
    parameter int DB_CYCLES = DB_CYCLES_DEFAULT,
    parameter int CNT_W     = 8
) (
    input  logic                       clock,
    input  logic                       reset,
    bbara_input_conditioner_if.slave   cond
);

    logic [BBARA_IN_W-1:0] level;
    logic [BBARA_IN_W-1:0] rise;
    logic [BBARA_IN_W-1:0] fall;
    logic [BBARA_IN_W-1:0] update_d;
    logic                  changed_q;

    for (genvar i = 0; i < BBARA_IN_W; i++) begin : g_bit
        bbara_debounce_bit #(
            .DB_CYCLES (DB_CYCLES),
            .CNT_W     (CNT_W)
        ) u_bit (
            .clock      (clock),
            .reset      (reset),
            .raw_i      (cond.raw_in[i]),
            .level_o    (level[i]),
            .rise_o     (rise[i]),
            .fall_o     (fall[i]),
            .update_d_o (update_d[i])
        );
    end

    // Registered from the per-bit update strobes so it lines up with rise/fall.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            changed_q <= 1'b0;
        end else begin
            changed_q <= |update_d;
        end
    end

    assign cond.bbara_in = level;
    assign cond.rise     = rise;
    assign cond.fall     = fall;
    assign cond.changed  = changed_q;

endmodule

// File: doc/bbara_input_conditioner.md
# bbara_input_conditioner

Input conditioning stage directly upstream of the bbara control state machine. Takes four asynchronous, possibly bouncing raw inputs, synchronizes each to `clock`, debounces each bit independently, and drives the clean 4-bit vector that feeds the state machine's `bbara_in`. Also emits per-bit edge pulses and a change strobe for monitoring logic.

## Interface
- `DB_CYCLES`, default 4: consecutive synchronized cycles a new level must hold before it is accepted; legal range 1..255.
- `CNT_W`, default 8: debounce counter width; must satisfy 2^CNT_W > DB_CYCLES.

- `clock`  in  1  single clock; all flops rise-edge triggered.
- `reset`  in  1  asynchronous, active-low reset (asserted at 0).
- `raw_in`  in  4  asynchronous raw inputs.
- `bbara_in`  out  4  debounced, synchronized vector to the state machine.
- `rise`  out  4  one-cycle pulse per bit, concurrent with a 0->1 update of that bit of `bbara_in`.
- `fall`  out  4  one-cycle pulse per bit, concurrent with a 1->0 update.
- `changed`  out  1  one-cycle pulse when any bit of `bbara_in` updates; equals OR of `rise|fall`.

## Operation
- Per bit: 2-flop synchronizer `s1 <= raw_in[i]`, `s2 <= s1`; then debounce cell comparing `s2` with `bbara_in[i]`.
- Debounce cell states: STABLE (`s2 == bbara_in[i]`, counter held at 0) and COUNTING (`s2 != bbara_in[i]`).
- STABLE -> COUNTING: first edge where `s2` differs; counter 0 -> 1.
- COUNTING, `s2` still differs, counter < DB_CYCLES-1: counter +1.
- COUNTING, `s2` still differs, counter == DB_CYCLES-1: `bbara_in[i] <= s2`, counter <= 0, pulse `rise[i]` or `fall[i]`, return to STABLE.
- COUNTING, `s2` equals `bbara_in[i]` again (glitch): counter <= 0, STABLE, no output change, no pulse.
- DB_CYCLES == 1: update on the first differing edge (STABLE -> update directly).
- Counter never exceeds DB_CYCLES-1; no wrap possible.
- Bits are fully independent; several bits may update on the same edge, each pulses its own `rise`/`fall`; `changed` is a single one-cycle pulse.
- All outputs registered; no combinational path from `raw_in` to any output.

## Timing
- Reset (async, `reset` = 0): `s1`, `s2`, counters, `bbara_in`, `rise`, `fall`, `changed` all 0 immediately; release is synchronous to next rising edge.
- Reset mid-count: count discarded; after release, a raw input held at 1 needs full DB_CYCLES+2 edges to appear.
- Latency: raw level stable before edge 1 -> `s2` new at edge 2 -> `bbara_in` updates at edge DB_CYCLES+2 (6 for default). Pulses high for exactly the cycle following that edge.
- Minimum accepted pulse width at `s2`: DB_CYCLES cycles; shorter excursions are filtered.
- Toggle faster than DB_CYCLES cycles indefinitely: `bbara_in` holds its value forever.

## Structure
- Shared package `bbara_pkg`: `BBARA_IN_W = 4`, `BBARA_OUT_W = 2`, default `DB_CYCLES`, and the debounce state enum (STABLE, COUNTING); shared with the bbara state machine.
- One sub-module `bbara_debounce_bit` (synchronizer + counter + state + edge pulses for one bit), instantiated 4 times by generate; top level forms `changed` as registered OR.

## Test plan
- Reset: hold `reset`=0 with `raw_in`=4'hF -> all outputs 0; release, keep 4'hF -> `bbara_in`=4'hF at edge 6, `rise`=4'hF and `changed`=1 for one cycle.
- Clean step: `raw_in` 4'h0 -> 4'b0011 held -> `bbara_in`=4'b0011 exactly 6 edges later, `rise`=4'b0011, `fall`=0.
- Glitch: bit 2 high for 3 cycles then low -> `bbara_in` unchanged, no pulses; repeat with 4 cycles -> bit 2 rises, then falls 4 cycles later.
- Independent bits: bit 0 rises at cycle 0, bit 3 at cycle 2 -> separate `rise` pulses 2 cycles apart, two `changed` pulses.
- Async reset mid-count: assert `reset` at counter=2 between edges -> outputs 0 without waiting for an edge; after release, full 6-edge latency.
- DB_CYCLES=1 instance: raw step -> `bbara_in` updates at edge 3; 1-cycle raw pulse passes through.
